elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Controller for a 4-floor single-car elevator.
- Latches hall calls (U up, D down) and car calls (F) and tracks the car position from one-hot floor sensors (S).
- Drives the motor command (AC), the floor display (DISP) and the door (open).
- Sits between the button/sensor I/O and the motor/door drivers.

Parameters:
- NFLOORS, 4, number of floors; the port widths below assume 4.
- DOOR_CYCLES, 3, clock cycles the door stays open per stop (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- F  in  4  car-panel floor request, bit i = floor i, level-sampled.
- S  in  4  floor position sensors, bit i high while the car is at floor i.
- D  in  4  hall down-call buttons (bit 0 ignored).
- U  in  4  hall up-call buttons (bit 3 ignored).
- AC  out  2  motor command: 00 stop, 01 up, 10 down, 11 never driven.
- DISP  out  3  current floor number, 1..4 (= floor index + 1).
- open  out  1  door open.

Behaviour:
- Reset (async): pending requests cleared, floor index 0, state IDLE, AC=00, DISP=3'd1, open=0, direction flag = up.
- Request latch:
  - Each posedge: req <= req | F | U | D, with U[3] and D[0] masked.
  - A request bit stays set until served.
  - Serving floor i clears req[i] on the cycle the door opens.
  - A button held during DOOR_OPEN at the current floor re-latches only after the door closes. While the door is open, req[cur] stays cleared.
- Position:
  - cur <= index of the lowest set bit of S; S==0 keeps cur.
  - DISP = cur+1, registered, updated in the same cycle as cur.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
  - IDLE:
    - If req[cur]: go to DOOR_OPEN.
    - Else if any req above cur and (dir==up or none below): go to MOVE_UP, dir=up.
    - Else if any req below: go to MOVE_DOWN, dir=down.
    - Else stay.
  - MOVE_UP: AC=01. When S indicates a floor with a pending req: AC=00 and go to DOOR_OPEN the next cycle.
  - MOVE_DOWN: AC=10, mirrored.
  - A move never overshoots floor 3 or floor 0. If cur hits the limit with nothing pending, go to IDLE.
  - DOOR_OPEN:
    - open=1, AC=00, down-counter loaded with DOOR_CYCLES-1.
    - On expiry: open=0, go to IDLE.
    - The IDLE decision then keeps dir, giving collective SCAN order.
- Outputs are registered. AC and open change one cycle after the decision inputs are sampled.
- Latency: a request at the current floor in IDLE gives open=1 two posedges after the request is first sampled.
- Simultaneous events:
  - Requests above and below with dir==up: serve up first.
  - Multiple S bits set: lowest index wins.
  - AC and open are never active together.
- Reset mid-move or with the door open: immediate return to the reset values. Pending requests are lost.

Optional Feature:
- Macro ELEV_REVERSE_PAUSE_EN.
- When defined: any change of direction (MOVE_UP↔MOVE_DOWN via IDLE) inserts one extra IDLE cycle with AC=00 before the new motor command.
- When undefined: a direction change can command the new direction on the first IDLE decision cycle.

Decomposition:
- Shared package elevator_pkg:
  - State enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN).
  - AC encodings AC_STOP=2'b00, AC_UP=2'b01, AC_DOWN=2'b10.
  - NFLOORS.
- One natural sub-module: elevator_req_latch. It holds the request register with its set/clear logic and the above/below/at-current reductions.
- FSM, position tracking and the door timer stay in the top.

Test Plan:
- Reset asserted for 10 ns → AC=00, DISP=1, open=0. Reset deasserts with no inputs → outputs unchanged for 10 cycles.
- U[1]=1 and S[1]=1 for 2 cycles → DISP=2, AC stays 00, open=1 for exactly 3 cycles, then 0. req[1] is cleared.
- Car at floor 1, then D[3]=1 with S stepping 0010→0100→1000 → AC=01 until S[3]. Then AC=00, DISP=4, open pulses 3 cycles.
- Car at floor 3, D[2]=1, then U[0]=1 while descending → stop at floor 2 (open 3 cycles), then AC=10 resumes to floor 0. At the end DISP=1 and req=0.
- Car at floor 0, D[2] pending, F[1] pressed during the climb → stop at floor 1 first, then floor 2. This exercises SCAN order.
- Reset asserted while AC=01 → AC=00, open=0, DISP=1 asynchronously, with no clock edge required.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types, encodings and helpers for the 4-floor elevator controller.
package elevator_pkg;

  localparam int unsigned NFLOORS = 4;
  localparam int unsigned FLOOR_W = $clog2(NFLOORS);
  localparam int unsigned AC_W    = 2;
  localparam int unsigned DISP_W  = 3;

  typedef logic [NFLOORS-1:0] floor_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

  localparam logic [AC_W-1:0] AC_STOP = 2'b00;
  localparam logic [AC_W-1:0] AC_UP   = 2'b01;
  localparam logic [AC_W-1:0] AC_DOWN = 2'b10;

  // Index of the lowest set bit; dflt when no bit is set.
  function automatic logic [FLOOR_W-1:0] lowest_idx(input floor_vec_t v,
                                                    input logic [FLOOR_W-1:0] dflt);
    lowest_idx = dflt;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = FLOOR_W'(i);
    end
  endfunction

endpackage

// File: rtl/elevator_if.sv
// Button/sensor inputs and motor/display/door outputs of the elevator controller.
interface elevator_if;
  import elevator_pkg::*;

  floor_vec_t        F;
  floor_vec_t        S;
  floor_vec_t        D;
  floor_vec_t        U;
  logic [AC_W-1:0]   AC;
  logic [DISP_W-1:0] DISP;
  logic              open;

  modport master (output F, S, D, U, input AC, DISP, open);
  modport slave  (input F, S, D, U, output AC, DISP, open);

endinterface

// File: rtl/elevator_req_latch.sv
// Pending-request register with per-floor clear and above/below/at-position reductions.
module elevator_req_latch
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  floor_vec_t         f,
  input  floor_vec_t         u,
  input  floor_vec_t         d,
  input  floor_vec_t         clr,
  input  logic [FLOOR_W-1:0] pos,
  output floor_vec_t         req,
  output logic               at_cur_c,
  output logic               above_c,
  output logic               below_c
);

  localparam floor_vec_t BOT_BIT = floor_vec_t'(1);
  localparam floor_vec_t TOP_BIT = floor_vec_t'(1) << (NFLOORS - 1);

  // No up call exists at the top floor and no down call at the bottom.
  floor_vec_t calls_c;
  assign calls_c = f | (u & ~TOP_BIT) | (d & ~BOT_BIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req <= '0;
    else       req <= (req | calls_c) & ~clr;
  end

  always_comb begin
    above_c  = 1'b0;
    below_c  = 1'b0;
    at_cur_c = req[pos];
    for (int i = 0; i < NFLOORS; i++) begin
      if (FLOOR_W'(i) > pos) above_c = above_c | req[i];
      if (FLOOR_W'(i) < pos) below_c = below_c | req[i];
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: position tracking, motion FSM and door timer.
// Define ELEV_REVERSE_PAUSE_EN to insert one stopped IDLE cycle on every direction reversal.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 3
)
(
  input logic       clk,
  input logic       reset,
  elevator_if.slave bus
);

  localparam int unsigned CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t             state_q, state_d;
  logic               dir_q, dir_d;        // 1 = up
  logic [FLOOR_W-1:0] cur_q, pos_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AC_W-1:0]    ac_q, ac_d;
  logic [DISP_W-1:0]  disp_q;
  logic               open_q, open_d;
  floor_vec_t         req, clr_c;
  logic               at_cur_c, above_c, below_c;

  // Sensors win over the stored position; a dark sensor bank holds the last floor.
  assign pos_c = lowest_idx(bus.S, cur_q);
  assign clr_c = (state_d == DOOR_OPEN) ? (floor_vec_t'(1) << pos_c) : '0;

  elevator_req_latch u_req (
    .clk      (clk),
    .reset    (reset),
    .f        (bus.F),
    .u        (bus.U),
    .d        (bus.D),
    .clr      (clr_c),
    .pos      (pos_c),
    .req      (req),
    .at_cur_c (at_cur_c),
    .above_c  (above_c),
    .below_c  (below_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      cur_q   <= '0;
      cnt_q   <= '0;
      ac_q    <= AC_STOP;
      disp_q  <= DISP_W'(1);
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= pos_c;
      cnt_q   <= cnt_d;
      ac_q    <= ac_d;
      disp_q  <= DISP_W'(pos_c) + DISP_W'(1);
      open_q  <= open_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    ac_d    = AC_STOP;
    open_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (at_cur_c) begin
          state_d = DOOR_OPEN;
          cnt_d   = CNT_LOAD;
        end else if (above_c && (dir_q || !below_c)) begin
`ifdef ELEV_REVERSE_PAUSE_EN
          if (!dir_q) dir_d   = 1'b1;
          else        state_d = MOVE_UP;
`else
          state_d = MOVE_UP;
          dir_d   = 1'b1;
`endif
        end else if (below_c) begin
`ifdef ELEV_REVERSE_PAUSE_EN
          if (dir_q) dir_d   = 1'b0;
          else       state_d = MOVE_DOWN;
`else
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
`endif
        end
      end
      MOVE_UP: begin
        if (at_cur_c) begin
          state_d = DOOR_OPEN;
          cnt_d   = CNT_LOAD;
        end else if (!above_c) begin
          state_d = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (at_cur_c) begin
          state_d = DOOR_OPEN;
          cnt_d   = CNT_LOAD;
        end else if (!below_c) begin
          state_d = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Outputs decode the next state so they register alongside it.
    if (state_d == MOVE_UP)        ac_d = AC_UP;
    else if (state_d == MOVE_DOWN) ac_d = AC_DOWN;
    open_d = (state_d == DOOR_OPEN);
  end

  assign bus.AC   = ac_q;
  assign bus.DISP = disp_q;
  assign bus.open = open_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed scoreboard bench for elevator_ctrl: expected outputs are queued per step and checked after each edge.
module tb_elevator_ctrl;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic reset;

  elevator_if bus ();

  elevator_ctrl #(.DOOR_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ac;
    logic [2:0] disp;
    logic       open;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } sb_t;

  sb_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input floor_vec_t f, input floor_vec_t s,
                       input floor_vec_t u, input floor_vec_t d);
    bus.F = f;
    bus.S = s;
    bus.U = u;
    bus.D = d;
  endtask

  task automatic push(input string tag, input logic [1:0] ac,
                      input logic [2:0] disp, input logic op);
    sb_t e;
    e.tag      = tag;
    e.exp.ac   = ac;
    e.exp.disp = disp;
    e.exp.open = op;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    sb_t  e;
    out_t obs;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=no_entry expected=entry");
      return;
    end
    e   = sbq.pop_front();
    obs = {bus.AC, bus.DISP, bus.open};
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed ac=%b disp=%0d open=%b expected ac=%b disp=%0d open=%b",
             e.tag, obs.ac, obs.disp, obs.open, e.exp.ac, e.exp.disp, e.exp.open);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] ac,
                      input logic [2:0] disp, input logic op);
    push(tag, ac, disp, op);
    tick();
    pop_check();
  endtask

  task automatic check_req(input string tag, input floor_vec_t exp);
    checks++;
    assert (dut.u_req.req === exp) else begin
      failures++;
      $error("FAIL %s observed req=%b expected req=%b", tag, dut.u_req.req, exp);
    end
  endtask

  initial begin
    // Reset and quiet idle
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #2;
    push("rst_async", 2'b00, 3'd1, 1'b0);
    pop_check();
    check_req("rst_req", 4'b0000);
    #8;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step($sformatf("idle_%0d", i), 2'b00, 3'd1, 1'b0);

    // Hall call at the floor the car sits on
    drive(4'b0000, 4'b0010, 4'b0010, 4'b0000);
    step("t2_arrive", 2'b00, 3'd2, 1'b0);
    step("t2_open0", 2'b00, 3'd2, 1'b1);
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step("t2_open1", 2'b00, 3'd2, 1'b1);
    step("t2_open2", 2'b00, 3'd2, 1'b1);
    step("t2_close", 2'b00, 3'd2, 1'b0);
    check_req("t2_req", 4'b0000);
    step("t2_idle", 2'b00, 3'd2, 1'b0);

    // Climb from floor 1 to a down call at floor 3
    drive(4'b0000, 4'b0010, 4'b0000, 4'b1000);
    step("t3_latch", 2'b00, 3'd2, 1'b0);
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step("t3_up", 2'b01, 3'd2, 1'b0);
    drive(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step("t3_pass2", 2'b01, 3'd3, 1'b0);
    drive(4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step("t3_open0", 2'b00, 3'd4, 1'b1);
    step("t3_open1", 2'b00, 3'd4, 1'b1);
    step("t3_open2", 2'b00, 3'd4, 1'b1);
    step("t3_close", 2'b00, 3'd4, 1'b0);
    check_req("t3_req", 4'b0000);

    // Descend with an intermediate stop, then continue to floor 0
    drive(4'b0000, 4'b1000, 4'b0000, 4'b0100);
    step("t4_latch", 2'b00, 3'd4, 1'b0);
    drive(4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step("t4_down", 2'b10, 3'd4, 1'b0);
    drive(4'b0000, 4'b0100, 4'b0001, 4'b0000);
    step("t4_stop2", 2'b00, 3'd3, 1'b1);
    drive(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    check_req("t4_req_mid", 4'b0001);
    step("t4_open1", 2'b00, 3'd3, 1'b1);
    step("t4_open2", 2'b00, 3'd3, 1'b1);
    step("t4_close", 2'b00, 3'd3, 1'b0);
    step("t4_resume", 2'b10, 3'd3, 1'b0);
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step("t4_pass1", 2'b10, 3'd2, 1'b0);
    drive(4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step("t4_stop0", 2'b00, 3'd1, 1'b1);
    step("t4_open1b", 2'b00, 3'd1, 1'b1);
    step("t4_open2b", 2'b00, 3'd1, 1'b1);
    step("t4_closeb", 2'b00, 3'd1, 1'b0);
    check_req("t4_req_end", 4'b0000);

    // SCAN order: car call at floor 1 joins a climb towards floor 2
    drive(4'b0000, 4'b0001, 4'b0000, 4'b0100);
    step("t5_latch", 2'b00, 3'd1, 1'b0);
    drive(4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step("t5_up", 2'b01, 3'd1, 1'b0);
    drive(4'b0010, 4'b0001, 4'b0000, 4'b0000);
    step("t5_carcall", 2'b01, 3'd1, 1'b0);
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step("t5_stop1", 2'b00, 3'd2, 1'b1);
    check_req("t5_req_mid", 4'b0100);
    step("t5_open1", 2'b00, 3'd2, 1'b1);
    step("t5_open2", 2'b00, 3'd2, 1'b1);
    step("t5_close1", 2'b00, 3'd2, 1'b0);
    step("t5_up2", 2'b01, 3'd2, 1'b0);
    drive(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step("t5_stop2", 2'b00, 3'd3, 1'b1);
    step("t5_open1b", 2'b00, 3'd3, 1'b1);
    step("t5_open2b", 2'b00, 3'd3, 1'b1);
    step("t5_close2", 2'b00, 3'd3, 1'b0);
    check_req("t5_req_end", 4'b0000);

    // Asynchronous reset while climbing
    drive(4'b1000, 4'b0100, 4'b0000, 4'b0000);
    step("t6_latch", 2'b00, 3'd3, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("t6_up", 2'b01, 3'd3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    push("t6_rst", 2'b00, 3'd1, 1'b0);
    pop_check();
    check_req("t6_req", 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    step("t6_idle0", 2'b00, 3'd1, 1'b0);
    step("t6_idle1", 2'b00, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
